adc_avg_acquire: RTL and testbench
==================================

Name: adc_avg_acquire

Overview:
Parametrised successor of the single-shot 8-sample ADC averaging acquirer. One sync pulse starts a burst of N = 2**LOG2_N ADC conversions, with programmable request timing and a ready timeout. Samples are summed in a running accumulator instead of an N-entry sample array. The block emits one averaged word per burst with a one-cycle valid strobe, and re-arms for the next burst. It sits between the ADC handshake interface and downstream filtering/telemetry logic.

Parameters:
DATA_W, 12, ADC sample and output width.
LOG2_N, 3, log2 of samples per burst (0..6).
REQ_DLY, 11, cycles from accepted syncro_i (or previous sample) to request assertion (>=1).
REQ_LEN, 2, cycles adc_data_req_o is held high (>=2).
TIMEOUT, 255, max cycles waiting for adc_data_rdy_i after request deasserts.
SIGNED, 1, 1 = two's-complement samples/arithmetic shift; 0 = unsigned.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-high (despite the _n suffix); clock clk_i
syncro_i  in  1  burst start, level sampled in IDLE, >=1 cycle
adc_data_req_o  out  1  conversion request to ADC
adc_data_rdy_i  in  1  ADC data valid
adc_data_i  in  DATA_W  ADC sample
data_o  out  DATA_W  averaged result, held until next result
data_rdy_o  out  1  one-cycle strobe, data_o new
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  one-cycle strobe, burst aborted

Behaviour:
- Reset (any time, including mid-burst):
  - all outputs 0, state IDLE, counters 0, accumulator 0.
  - Effect is immediate (async); release is synchronous to clk_i.
- Accumulator: ACC_W = DATA_W+LOG2_N bits.
  - Sample is sign-extended if SIGNED=1, else zero-extended.
  - No overflow is possible by construction.
- FSM states: IDLE, DELAY, REQ, WAIT_RDY, DONE.
- IDLE:
  - syncro_i=1 at edge k -> DELAY; accumulator and sample count cleared.
  - syncro_i is ignored in every other state (no queuing).
- DELAY:
  - counts REQ_DLY cycles.
  - adc_data_req_o rises at edge k+REQ_DLY -> REQ.
- REQ:
  - adc_data_req_o high for exactly REQ_LEN cycles, then low -> WAIT_RDY.
  - adc_data_rdy_i is ignored in DELAY and REQ.
- WAIT_RDY, on adc_data_rdy_i=1:
  - accumulate adc_data_i; sample count +1.
  - if count < N -> DELAY (next conversion, REQ_DLY measured from this edge).
  - if count reaches N -> DONE.
- WAIT_RDY timeout:
  - if TIMEOUT cycles elapse without rdy -> timeout_o=1 for one cycle, accumulator cleared, -> IDLE.
  - data_o is unchanged and no data_rdy_o is issued.
  - rdy arriving in the same cycle the timeout expires: the sample wins and the timeout is not flagged.
- DONE (one cycle):
  - data_o <= acc >> LOG2_N (arithmetic shift if SIGNED, i.e. floor); data_rdy_o=1 for one cycle -> IDLE.
  - Latency: data_rdy_o is high the cycle after the edge sampling the Nth rdy.
  - syncro_i high during DONE is ignored; it is accepted the next cycle if still high.
- LOG2_N=0: single sample passed through unchanged.

Optional Feature:
- Macro ADC_AVG_ACQUIRE_ROUND_EN.
- Defined: DONE adds 2**(LOG2_N-1) to the accumulator before the shift (round half up). The sum still fits in ACC_W for full-scale inputs, so no saturation is needed. Rounding is disabled when LOG2_N=0.
- Undefined: truncation/floor as above.

Decomposition:
- Package adc_acq_pkg:
  - FSM state enum.
  - localparam function for ACC_W.
  - counter-width function (clog2 of max(REQ_DLY, REQ_LEN, TIMEOUT) + 1).
- Sub-module adc_acq_accum:
  - clear/accumulate/extend logic.
  - shift plus optional rounding, producing the DATA_W result.
  - The FSM and handshake stay in the top.

Test Plan:
- Defaults, syncro at cycle 5, ADC returns 100 two cycles after each request fall -> 8 requests, each high 2 cycles and rising 11 cycles after the preceding syncro/rdy; one data_rdy_o pulse with data_o=100.
- Unsigned samples 0..7 -> data_o=3; with ADC_AVG_ACQUIRE_ROUND_EN -> 4.
- SIGNED=1, all samples 12'hFFF (-1) -> data_o=12'hFFF; samples -2048 x8 -> 12'h800; samples 2047 x8 -> 12'h7FF.
- rdy withheld after the 3rd request for 255 cycles -> timeout_o pulse, no data_rdy_o, data_o keeps its prior value, busy_o drops; the next syncro completes normally.
- syncro_i pulsed during DELAY/REQ/WAIT_RDY and held high through the burst -> ignored mid-burst; the held level starts a new burst the cycle after DONE.
- reset_n_i pulsed high in the middle of REQ -> adc_data_req_o, busy_o and data_o go to 0 without a clock edge; the following burst result is unaffected by the pre-reset samples.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared types and sizing helpers for the ADC burst-averaging acquirer.
package adc_acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    REQ,
    WAIT_RDY,
    DONE
  } acq_state_t;

  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  // Wide enough to hold the largest of the delay, request-length and timeout counts.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_acq_accum.sv
// Running-sum accumulator and averaged-result register for adc_avg_acquire.
// Honours ADC_AVG_ACQUIRE_ROUND_EN (round half up before the final shift).
module adc_acq_accum
  import adc_acq_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 3,
  parameter int SIGNED = 1
) (
  input  logic              clk_i,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_add,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_sample,
  output logic [DATA_W-1:0] o_data
);

  localparam int ACC_W = acc_w(DATA_W, LOG2_N);
`ifdef ADC_AVG_ACQUIRE_ROUND_EN
  localparam int HALF_SH = (LOG2_N > 0) ? LOG2_N - 1 : 0;
  localparam logic signed [ACC_W-1:0] HALF = (LOG2_N > 0) ? (ACC_W'(1) << HALF_SH) : '0;
`endif

  logic signed [ACC_W-1:0] r_acc;
  logic        [DATA_W-1:0] r_data;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;

  function automatic logic [DATA_W-1:0] avg_out(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] s;
    s = sum;
`ifdef ADC_AVG_ACQUIRE_ROUND_EN
    s = s + HALF;
`endif
    if (SIGNED != 0) return DATA_W'(s >>> LOG2_N);
    return DATA_W'($unsigned(s) >> LOG2_N);
  endfunction

  always_comb begin
    if (SIGNED != 0) w_ext = ACC_W'(signed'(i_sample));
    else             w_ext = signed'(ACC_W'(i_sample));
  end

  assign w_sum = r_acc + w_ext;

  // The result is taken from the sum including the sample being accepted,
  // so it is ready in the same cycle the FSM enters DONE.
  always_ff @(posedge clk_i or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_data <= '0;
    end else begin
      if (i_clr)      r_acc <= '0;
      else if (i_add) r_acc <= w_sum;
      if (i_load)     r_data <= avg_out(w_sum);
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/adc_avg_acquire.sv
// Burst ADC acquirer: one sync pulse triggers 2**LOG2_N conversions whose mean is emitted.
// Optional rounding via ADC_AVG_ACQUIRE_ROUND_EN (see adc_acq_accum).
module adc_avg_acquire
  import adc_acq_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int LOG2_N  = 3,
  parameter int REQ_DLY = 11,
  parameter int REQ_LEN = 2,
  parameter int TIMEOUT = 255,
  parameter int SIGNED  = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              syncro_i,
  output logic              adc_data_req_o,
  input  logic              adc_data_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int CNT_W  = cnt_w(REQ_DLY, REQ_LEN, TIMEOUT);
  localparam int SCNT_W = LOG2_N + 1;
  localparam int N      = 1 << LOG2_N;
  localparam logic [CNT_W-1:0]  DLY_LAST = CNT_W'(REQ_DLY - 1);
  localparam logic [CNT_W-1:0]  LEN_LAST = CNT_W'(REQ_LEN - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] SMP_LAST = SCNT_W'(N - 1);

  acq_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SCNT_W-1:0] r_scnt, w_scnt_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_clr, w_add, w_load;

  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_scnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_scnt    <= w_scnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_scnt_nxt    = r_scnt;
    w_timeout_nxt = 1'b0;
    w_clr         = 1'b0;
    w_add         = 1'b0;
    w_load        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (syncro_i) begin
          w_state_nxt = DELAY;
          w_cnt_nxt   = '0;
          w_scnt_nxt  = '0;
          w_clr       = 1'b1;
        end
      end
      DELAY: begin
        if (r_cnt == DLY_LAST) begin
          w_state_nxt = REQ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      REQ: begin
        if (r_cnt == LEN_LAST) begin
          w_state_nxt = WAIT_RDY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_RDY: begin
        // A sample arriving on the expiry cycle takes priority over the timeout.
        if (adc_data_rdy_i) begin
          w_add      = 1'b1;
          w_cnt_nxt  = '0;
          w_scnt_nxt = r_scnt + 1'b1;
          if (r_scnt == SMP_LAST) begin
            w_load      = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = DELAY;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_clr         = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  adc_acq_accum #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N),
    .SIGNED (SIGNED)
  ) u_accum (
    .clk_i    (clk_i),
    .i_rst    (reset_n_i),
    .i_clr    (w_clr),
    .i_add    (w_add),
    .i_load   (w_load),
    .i_sample (adc_data_i),
    .o_data   (data_o)
  );

  assign adc_data_req_o = (r_state == REQ);
  assign data_rdy_o     = (r_state == DONE);
  assign busy_o         = (r_state != IDLE);
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_adc_avg_acquire.sv
// Directed bench for adc_avg_acquire: a signed (default) and an unsigned instance share stimulus.
module tb_adc_avg_acquire;

  localparam int REQ_DLY = 11;
  localparam int REQ_LEN = 2;
`ifdef ADC_AVG_ACQUIRE_ROUND_EN
  localparam logic [11:0] RAMP_AVG = 12'd4;
`else
  localparam logic [11:0] RAMP_AVG = 12'd3;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        syncro_i;
  logic        adc_data_rdy_i;
  logic [11:0] adc_data_i;
  logic        adc_data_req_o, data_rdy_o, busy_o, timeout_o;
  logic [11:0] data_o;
  logic        req_u, drdy_u, busy_u, tmo_u;
  logic [11:0] data_u;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] smp [8];
  logic [11:0] exp_s, exp_u;

  always #5 clk_i = ~clk_i;

  adc_avg_acquire u_dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .syncro_i       (syncro_i),
    .adc_data_req_o (adc_data_req_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i),
    .data_o         (data_o),
    .data_rdy_o     (data_rdy_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  adc_avg_acquire #(.SIGNED(0)) u_dut_u (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .syncro_i       (syncro_i),
    .adc_data_req_o (req_u),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i),
    .data_o         (data_u),
    .data_rdy_o     (drdy_u),
    .busy_o         (busy_u),
    .timeout_o      (tmo_u)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_req(input bit poke, output int n);
    n = 0;
    do begin
      if (poke && n == 0) syncro_i = 1'b1;
      step();
      if (poke && n == 0) syncro_i = 1'b0;
      n++;
    end while (!adc_data_req_o && n < 40);
  endtask

  task automatic req_phase(input bit poke, input string tag);
    int n, len;
    wait_req(poke, n);
    chk({tag, "_req_dly"}, n, REQ_DLY);
    len = 0;
    do begin
      if (poke && len == 0) syncro_i = 1'b1;
      step();
      if (poke && len == 0) syncro_i = 1'b0;
      len++;
    end while (adc_data_req_o && len < 10);
    chk({tag, "_req_len"}, len, REQ_LEN);
  endtask

  task automatic give_rdy(input logic [11:0] s, input bit poke);
    if (poke) syncro_i = 1'b1;
    step();
    if (poke) syncro_i = 1'b0;
    adc_data_i     = s;
    adc_data_rdy_i = 1'b1;
    step();
    adc_data_rdy_i = 1'b0;
    adc_data_i     = '0;
  endtask

  task automatic start(input bit hold, input string tag);
    syncro_i = 1'b1;
    step();
    if (!hold) syncro_i = 1'b0;
    chk({tag, "_busy_start"}, busy_o, 1'b1);
  endtask

  task automatic run_burst(input string tag, input bit poke, input bit hold);
    start(hold, tag);
    for (int i = 0; i < 8; i++) begin
      req_phase(poke, tag);
      give_rdy(smp[i], poke);
    end
    chk({tag, "_drdy"}, data_rdy_o, 1'b1);
    chk({tag, "_data_s"}, data_o, exp_s);
    chk({tag, "_drdy_u"}, drdy_u, 1'b1);
    chk({tag, "_data_u"}, data_u, exp_u);
    chk({tag, "_tmo"}, timeout_o, 1'b0);
    step();
    chk({tag, "_drdy_off"}, data_rdy_o, 1'b0);
    chk({tag, "_idle"}, busy_o, 1'b0);
    step();
    chk({tag, "_rearm"}, busy_o, hold);
  endtask

  initial begin
    int n;
    bit seen_drdy;
    reset_n_i      = 1'b1;
    syncro_i       = 1'b0;
    adc_data_rdy_i = 1'b0;
    adc_data_i     = '0;
    step();
    step();
    chk("rst_req", adc_data_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_drdy", data_rdy_o, 1'b0);
    chk("rst_tmo", timeout_o, 1'b0);
    chk("rst_data", data_o, 12'h000);
    reset_n_i = 1'b0;
    repeat (3) step();

    foreach (smp[i]) smp[i] = 12'd100;
    exp_s = 12'd100; exp_u = 12'd100;
    run_burst("avg100", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = 12'(i);
    exp_s = RAMP_AVG; exp_u = RAMP_AVG;
    run_burst("ramp", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = 12'hFFF;
    exp_s = 12'hFFF; exp_u = 12'hFFF;
    run_burst("neg1", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = 12'h800;
    exp_s = 12'h800; exp_u = 12'h800;
    run_burst("minneg", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = 12'h7FF;
    exp_s = 12'h7FF; exp_u = 12'h7FF;
    run_burst("maxpos", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = (i % 2 == 0) ? 12'hFFF : 12'h001;
    exp_s = 12'h000; exp_u = 12'h800;
    run_burst("alt", 1'b0, 1'b0);

    // Third request left unanswered.
    start(1'b0, "tmo");
    req_phase(1'b0, "tmo");
    give_rdy(12'd50, 1'b0);
    req_phase(1'b0, "tmo");
    give_rdy(12'd50, 1'b0);
    req_phase(1'b0, "tmo");
    n = 0;
    seen_drdy = 1'b0;
    do begin
      step();
      n++;
      if (data_rdy_o) seen_drdy = 1'b1;
    end while (!timeout_o && n < 300);
    chk("tmo_cycles", n, 255);
    chk("tmo_no_drdy", seen_drdy, 1'b0);
    chk("tmo_data_s", data_o, 12'h000);
    chk("tmo_data_u", data_u, 12'h800);
    chk("tmo_busy", busy_o, 1'b0);
    step();
    chk("tmo_pulse", timeout_o, 1'b0);

    foreach (smp[i]) smp[i] = 12'd20;
    exp_s = 12'd20; exp_u = 12'd20;
    run_burst("after_tmo", 1'b0, 1'b0);

    foreach (smp[i]) smp[i] = 12'd30;
    exp_s = 12'd30; exp_u = 12'd30;
    run_burst("poke", 1'b1, 1'b0);

    foreach (smp[i]) smp[i] = 12'd40;
    exp_s = 12'd40; exp_u = 12'd40;
    run_burst("hold", 1'b0, 1'b1);
    syncro_i = 1'b0;

    // The re-armed burst is interrupted by reset during its third request.
    req_phase(1'b0, "prerst");
    give_rdy(12'h7FF, 1'b0);
    req_phase(1'b0, "prerst");
    give_rdy(12'h7FF, 1'b0);
    wait_req(1'b0, n);
    chk("prerst_req_dly", n, REQ_DLY);
    #2 reset_n_i = 1'b1;
    #1;
    chk("arst_req", adc_data_req_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_data_s", data_o, 12'h000);
    chk("arst_data_u", data_u, 12'h000);
    #2 reset_n_i = 1'b0;
    step();

    foreach (smp[i]) smp[i] = 12'd8;
    exp_s = 12'd8; exp_u = 12'd8;
    run_burst("post_rst", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
